// File: rtl/program_loader.sv
// Copies a selected program from the program ROM into instruction memory,
// holding the downstream CPU in reset until the copy has settled.
module program_loader #(
  parameter int unsigned BASE_INDEX   = 10,
  parameter int unsigned NUM_PROGRAMS = 3,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned HOLD_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  program_select,
  output logic [7:0]  rom_program,
  output logic [7:0]  rom_offset,
  input  logic [15:0] rom_data,
  input  logic        rom_last,
  output logic        write_enable,
  output logic [7:0]  write_instruction_index,
  output logic [15:0] write_instruction,
  output logic        cpu_reset,
  output logic        busy,
  output logic [7:0]  loaded_program,
  output logic        error
);

  localparam logic [7:0] BASE        = 8'(BASE_INDEX);
  localparam logic [7:0] LAST_OFFSET = 8'(MAX_LEN - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, HOLD} state_t;

  state_t      state;
  logic [7:0]  offset;
  logic [3:0]  hold_cnt;
  logic [15:0] instr_q;
  logic [7:0]  requested;
  logic        start_c;

  // Switch value 0 selects program 1; 255 wraps to 0, which is never valid.
  assign requested = program_select + 8'd1;
  assign start_c   = (requested != 8'd0) && (32'(requested) <= NUM_PROGRAMS) &&
                     (requested != loaded_program);

  assign rom_program = loaded_program;
  assign rom_offset  = offset;

  // ROM data only arrives in the WRITE cycle, so it is forwarded during the strobe
  // and captured for the hold value afterwards.
  assign write_instruction = write_enable ? rom_data : instr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      cpu_reset               <= 1'b1;
      write_enable            <= 1'b0;
      offset                  <= 8'd0;
      hold_cnt                <= 4'd0;
      loaded_program          <= 8'd0;
      error                   <= 1'b0;
      busy                    <= 1'b0;
      instr_q                 <= 16'd0;
      write_instruction_index <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_c) begin
            state          <= FETCH;
            busy           <= 1'b1;
            cpu_reset      <= 1'b1;
            loaded_program <= requested;
            offset         <= 8'd0;
            error          <= 1'b0;
          end else begin
            cpu_reset <= 1'b0;
          end
        end
        FETCH: begin
          state                   <= WRITE;
          write_enable            <= 1'b1;
          write_instruction_index <= BASE + offset;
        end
        WRITE: begin
          write_enable <= 1'b0;
          instr_q      <= rom_data;
          if (rom_last || (offset == LAST_OFFSET)) begin
            state    <= HOLD;
            hold_cnt <= 4'd0;
            if (!rom_last) error <= 1'b1;
          end else begin
            offset <= offset + 8'd1;
            state  <= FETCH;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            // Keep the CPU in reset across the IDLE cycle when another load follows.
            cpu_reset <= start_c;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: registered ROM model, write capture monitor and a
// word-list reference model of what each load must produce.
module tb_program_loader;

  localparam int BASE_INDEX   = 10;
  localparam int NUM_PROGRAMS = 3;
  localparam int MAX_LEN      = 16;
  localparam int HOLD_CYCLES  = 2;

  logic        clk;
  logic        reset;
  logic [7:0]  program_select;
  logic [7:0]  rom_program;
  logic [7:0]  rom_offset;
  logic [15:0] rom_data;
  logic        rom_last;
  logic        write_enable;
  logic [7:0]  write_instruction_index;
  logic [15:0] write_instruction;
  logic        cpu_reset;
  logic        busy;
  logic [7:0]  loaded_program;
  logic        error;

  program_loader #(
    .BASE_INDEX(BASE_INDEX),
    .NUM_PROGRAMS(NUM_PROGRAMS),
    .MAX_LEN(MAX_LEN),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .program_select(program_select),
    .rom_program(rom_program),
    .rom_offset(rom_offset),
    .rom_data(rom_data),
    .rom_last(rom_last),
    .write_enable(write_enable),
    .write_instruction_index(write_instruction_index),
    .write_instruction(write_instruction),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .loaded_program(loaded_program),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program ROM: one-cycle read latency.
  logic [15:0] rom_mem [0:3][0:255];
  int          rom_len [0:3];

  always @(posedge clk) begin
    if (int'(rom_program) <= 3) begin
      rom_data <= rom_mem[rom_program[1:0]][rom_offset];
      rom_last <= (int'(rom_offset) == rom_len[rom_program[1:0]] - 1);
    end else begin
      rom_data <= 16'hdead;
      rom_last <= 1'b0;
    end
  end

  // Monitor: captured writes and cumulative cycle counters.
  logic [7:0]  cap_idx [0:1023];
  logic [15:0] cap_dat [0:1023];
  int cap_n       = 0;
  int busy_cyc    = 0;
  int cr_low      = 0;
  int we_in_reset = 0;

  always @(negedge clk) begin
    if (write_enable === 1'b1 && cap_n < 1024) begin
      cap_idx[cap_n] <= write_instruction_index;
      cap_dat[cap_n] <= write_instruction;
      cap_n          <= cap_n + 1;
    end
    if (cpu_reset !== 1'b1) cr_low <= cr_low + 1;
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    if (reset === 1'b1 && write_enable === 1'b1) we_in_reset <= we_in_reset + 1;
  end

  int   errors = 0;
  int   checks = 0;
  int   model_loaded = 0;
  logic model_error  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $error("FAIL %s.timeout: busy=%b after %0d cycles, required 0", tag, busy, budget);
    end
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int n = 0;
    while (cap_n < target && n < budget) begin
      step();
      n++;
    end
    if (cap_n < target) begin
      checks++;
      errors++;
      $error("FAIL %s.timeout: writes=%0d after %0d cycles, required %0d", tag, cap_n, budget, target);
    end
  endtask

  function automatic int words(input int p);
    return (rom_len[p] < MAX_LEN) ? rom_len[p] : MAX_LEN;
  endfunction

  task automatic check_words(input string tag, input int from, input int prog, input int n);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s.word%0d", tag, k), {8'h0, cap_idx[from + k], cap_dat[from + k]},
          {8'h0, 8'(BASE_INDEX + k), rom_mem[prog][k]});
  endtask

  task automatic check_done(input string tag, input int prog);
    int n = words(prog);
    model_loaded = prog;
    model_error  = (rom_len[prog] > MAX_LEN);
    chk({tag, ".loaded"}, 32'(loaded_program), 32'(model_loaded));
    chk({tag, ".error"}, 32'(error), 32'(model_error));
    chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'd0);
    chk({tag, ".we"}, 32'(write_enable), 32'd0);
    chk({tag, ".instr_hold"}, 32'(write_instruction), 32'(rom_mem[prog][n - 1]));
    chk({tag, ".index_hold"}, 32'(write_instruction_index), 32'(8'(BASE_INDEX + n - 1)));
  endtask

  // Select already applied while idle; one full load of prog is expected.
  task automatic expect_load(input string tag, input int prog);
    int c0 = cap_n;
    int b0 = busy_cyc;
    int r0 = cr_low;
    int n  = words(prog);
    step();
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    wait_idle(tag, 400);
    chk({tag, ".count"}, 32'(cap_n - c0), 32'(n));
    check_words(tag, c0, prog, n);
    chk({tag, ".busy_cycles"}, 32'(busy_cyc - b0), 32'(2 * n + HOLD_CYCLES));
    chk({tag, ".cpu_low_cycles"}, 32'(cr_low - r0), 32'd1);
    check_done(tag, prog);
  endtask

  task automatic expect_noload(input string tag);
    int c0 = cap_n;
    int b0 = busy_cyc;
    repeat (6) step();
    chk({tag, ".count"}, 32'(cap_n - c0), 32'd0);
    chk({tag, ".busy_cycles"}, 32'(busy_cyc - b0), 32'd0);
    chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'd0);
    chk({tag, ".loaded"}, 32'(loaded_program), 32'(model_loaded));
    chk({tag, ".error"}, 32'(error), 32'(model_error));
  endtask

  task automatic randomize_rom(input int lo, input int hi);
    for (int p = 1; p <= 3; p++) begin
      rom_len[p] = $urandom_range(hi, lo);
      for (int k = 0; k < 256; k++) rom_mem[p][k] = 16'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int b0;
    int r0;
    int w0;
    int req;
    logic [7:0] sel;

    reset          = 1'b1;
    program_select = 8'd0;
    for (int k = 0; k < 256; k++) rom_mem[0][k] = 16'($urandom);
    rom_len[0] = 0;
    randomize_rom(1, 1);
    rom_len[1] = 13;
    rom_len[2] = 7;
    rom_len[3] = 20;

    repeat (2) step();
    chk("rst.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst.we", 32'(write_enable), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.loaded", 32'(loaded_program), 32'd0);
    chk("rst.error", 32'(error), 32'd0);
    chk("rst.instr", 32'(write_instruction), 32'd0);
    chk("rst.index", 32'(write_instruction_index), 32'd0);
    chk("rst.offset", 32'(rom_offset), 32'd0);

    reset = 1'b0;
    expect_load("first_load", 1);

    program_select = 8'd1;
    expect_load("second_load", 2);

    program_select = 8'd5;
    expect_noload("out_of_range");
    program_select = 8'd1;
    expect_noload("same_program");
    program_select = 8'd255;
    expect_noload("wrap_zero");

    program_select = 8'd2;
    expect_load("truncate", 3);

    // Invalid request at reset release drops cpu_reset on the first edge.
    reset          = 1'b1;
    program_select = 8'd5;
    step();
    chk("inv_rel.cpu_reset_in_reset", 32'(cpu_reset), 32'd1);
    reset = 1'b0;
    step();
    chk("inv_rel.cpu_reset", 32'(cpu_reset), 32'd0);
    chk("inv_rel.busy", 32'(busy), 32'd0);
    chk("inv_rel.loaded", 32'(loaded_program), 32'd0);
    model_loaded = 0;
    model_error  = 1'b0;

    // Selection changed mid-load: program 1 finishes, program 3 follows seamlessly.
    c0 = cap_n;
    b0 = busy_cyc;
    r0 = cr_low;
    program_select = 8'd0;
    wait_writes("chain.first", c0 + 4, 100);
    program_select = 8'd2;
    wait_writes("chain.all", c0 + 13 + 16, 300);
    wait_idle("chain", 100);
    chk("chain.count", 32'(cap_n - c0), 32'd29);
    check_words("chain.p1", c0, 1, 13);
    check_words("chain.p3", c0 + 13, 3, 16);
    chk("chain.busy_cycles", 32'(busy_cyc - b0), 32'(2 * 13 + HOLD_CYCLES + 2 * 16 + HOLD_CYCLES));
    chk("chain.cpu_low_cycles", 32'(cr_low - r0), 32'd1);
    check_done("chain", 3);

    // Reset pulsed mid-load aborts; the current selection reloads from offset 0.
    program_select = 8'd0;
    c0 = cap_n;
    wait_writes("abort.pre", c0 + 6, 100);
    reset = 1'b1;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.we", 32'(write_enable), 32'd0);
    chk("abort.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("abort.loaded", 32'(loaded_program), 32'd0);
    chk("abort.instr", 32'(write_instruction), 32'd0);
    chk("abort.index", 32'(write_instruction_index), 32'd0);
    w0 = cap_n;
    repeat (3) step();
    chk("abort.no_writes", 32'(cap_n - w0), 32'd0);
    chk("abort.we_in_reset", 32'(we_in_reset), 32'd0);
    reset        = 1'b0;
    model_loaded = 0;
    expect_load("reload", 1);

    // Randomized requests and ROM contents against the model.
    for (int it = 0; it < 12; it++) begin
      randomize_rom(1, 20);
      if ($urandom_range(3, 0) == 0) sel = 8'($urandom_range(255, 0));
      else sel = 8'($urandom_range(3, 0));
      program_select = sel;
      req = (int'(sel) + 1) % 256;
      if (req >= 1 && req <= NUM_PROGRAMS && req != model_loaded)
        expect_load($sformatf("rand%0d", it), req);
      else
        expect_noload($sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter BASE_INDEX, default 10: instruction-memory index of the first word written.
REQ-002 SHALL have parameter NUM_PROGRAMS, default 3: highest valid program number; programs are numbered 1..NUM_PROGRAMS.
REQ-003 SHALL have parameter MAX_LEN, default 16: maximum words per program, 1..255.
REQ-004 SHALL have parameter HOLD_CYCLES, default 2: cycles cpu_reset stays high after the last write, 1..15.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 program_select  input  8  switch value; requested program = program_select + 1, wrapping mod 256.
REQ-008 rom_program  output  8  program number presented to the program ROM.
REQ-009 rom_offset  output  8  word offset within the program presented to the ROM.
REQ-010 rom_data  input  16  ROM word; valid one cycle after rom_program/rom_offset.
REQ-011 rom_last  input  1  set alongside rom_data when that word is the program's final word.
REQ-012 write_enable  output  1  one-cycle strobe: commit write_instruction at write_instruction_index.
REQ-013 write_instruction_index  output  8  destination index, BASE_INDEX + offset, truncated to 8 bits.
REQ-014 write_instruction  output  16  instruction word being written.
REQ-015 cpu_reset  output  1  holds the downstream CPU in reset while high.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 loaded_program  output  8  last program whose load started; 0 = none.
REQ-018 error  output  1  sticky truncation flag.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, WRITE, HOLD.
REQ-020 IDLE: when requested != loaded_program and 1 <= requested <= NUM_PROGRAMS, next cycle SHALL enter FETCH with cpu_reset=1, loaded_program=requested, offset=0, error=0.
REQ-021 IDLE, any other requested value: SHALL stay IDLE with cpu_reset=0 and no writes.
REQ-022 rom_program SHALL equal loaded_program and rom_offset SHALL equal the offset register in all states.
REQ-023 FETCH: SHALL go to WRITE after exactly one cycle, covering the ROM latency.
REQ-024 WRITE: SHALL assert write_enable for exactly one cycle, with write_instruction=rom_data and write_instruction_index=BASE_INDEX+offset.
REQ-025 WRITE with rom_last=0 and offset < MAX_LEN-1: SHALL increment offset and return to FETCH; sustained rate is one word per 2 cycles.
REQ-026 WRITE with rom_last=1: SHALL enter HOLD with error unchanged.
REQ-027 WRITE with rom_last=0 and offset == MAX_LEN-1: SHALL write the word, set error=1 and enter HOLD; no index beyond BASE_INDEX+MAX_LEN-1 is ever written.
REQ-028 HOLD: SHALL keep cpu_reset=1 for HOLD_CYCLES cycles, then enter IDLE and drive cpu_reset=0 in that IDLE cycle unless a new load starts.
REQ-029 cpu_reset SHALL be high continuously from load start until HOLD ends, with no glitch between words.
REQ-030 program_select changes outside IDLE SHALL be ignored and re-evaluated on return to IDLE; a differing valid request then starts a new load immediately.
REQ-031 write_enable SHALL be 0 in IDLE, FETCH and HOLD.
REQ-032 write_instruction and write_instruction_index SHALL hold their last values when write_enable=0.
REQ-033 Requesting the program already in loaded_program SHALL cause no reload.

Reset
REQ-034 On reset high, SHALL immediately force state=IDLE, cpu_reset=1, write_enable=0, offset=0, loaded_program=0, error=0, busy=0, write_instruction=0, write_instruction_index=0.
REQ-035 On reset release, a valid request SHALL start a load on the first clock edge; cpu_reset stays 1 throughout, so the CPU never runs unloaded code.
REQ-036 Reset asserted mid-load SHALL abort the load; no write_enable pulse occurs while reset is high.
REQ-037 With an invalid request after reset release, cpu_reset SHALL fall to 0 on the first clock edge.

Verification
REQ-038 Reset release, program_select=0, 13-word ROM program 1 (last on offset 12) -> 13 strobes at indices 10..22, 26 cycles, then 2 HOLD cycles, cpu_reset low, loaded_program=1, error=0.
REQ-039 Load 1 complete, select changed to 1 -> program 2 loaded at indices 10..16, cpu_reset high throughout, then low.
REQ-040 program_select=5 (requested 6 > NUM_PROGRAMS) -> no strobes, busy=0, loaded_program unchanged, cpu_reset=0.
REQ-041 ROM program with no rom_last over 20 words, MAX_LEN=16 -> strobes only at indices 10..25, error=1, cpu_reset released.
REQ-042 Select changed from 0 to 2 during word 4 of program 1 -> program 1 completes, then program 3 loads with no intervening cpu_reset low cycle.
REQ-043 Reset pulsed during word 6 -> no further strobes; loader restarts the current selection from offset 0 after release.
